// File: rtl/conv1d_mac_ctrl.sv
// conv1d_mac_ctrl: sequences xmem/fmem reads and MAC enables for a
// valid-mode 1-D convolution y[j] = relu(sum_k x[j+k]*f[k]).
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start/busy/done   top-level run control (done is a 1-cycle pulse)
//   mem_rd_en         read strobe shared by xmem and fmem
//   x_addr, f_addr    synchronous-read addresses (j+k and k)
//   en_mult_reg       MAC multiplier-register enable (issue delayed 1)
//   en_adder_reg      MAC accumulator enable (issue delayed 2)
//   reset_accum       MAC accumulator/multiplier clear
//   accum_in          finished MAC result (ReLU applied upstream)
//   y_valid/y_ready   output handshake, one word per j
//   y_data/y_addr     output word (pass-through of accum_in) and index j
module conv1d_mac_ctrl #(
  parameter int N   = 43,
  parameter int M   = 16,
  parameter int DW  = 32,
  parameter int XAW = $clog2(N),
  parameter int FAW = $clog2(M),
  parameter int YAW = (N - M + 1 > 1) ? $clog2(N - M + 1) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           mem_rd_en,
  output logic [XAW-1:0] x_addr,
  output logic [FAW-1:0] f_addr,
  output logic           en_mult_reg,
  output logic           en_adder_reg,
  output logic           reset_accum,
  input  logic [DW-1:0]  accum_in,
  output logic           y_valid,
  input  logic           y_ready,
  output logic [DW-1:0]  y_data,
  output logic [YAW-1:0] y_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_OUT,
    S_CLR,
    S_DONE
  } state_t;

  localparam logic [FAW-1:0] K_LAST = FAW'(M - 1);
  localparam logic [YAW-1:0] J_LAST = YAW'(N - M);

  state_t         state;
  state_t         state_nx;
  logic [FAW-1:0] k;
  logic [YAW-1:0] j;
  logic           drain_cnt;
  logic [1:0]     en_pipe;

  logic issue;
  logic k_last;
  logic j_last;
  logic y_fire;

  assign issue  = (state == S_RUN);
  assign k_last = (k == K_LAST);
  assign j_last = (j == J_LAST);
  assign y_fire = (state == S_OUT) && y_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (k_last) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // second drain cycle lets en_adder_reg retire the last product
        if (drain_cnt) begin
          state_nx = S_OUT;
        end
      end
      S_OUT: begin
        if (y_fire) begin
          state_nx = S_CLR;
        end
      end
      S_CLR: begin
        state_nx = j_last ? S_DONE : S_RUN;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
    mem_rd_en    = issue;
    reset_accum  = (state == S_IDLE) || (state == S_CLR);
    y_valid      = (state == S_OUT);
    en_mult_reg  = en_pipe[0];
    en_adder_reg = en_pipe[1];
    x_addr       = XAW'(j) + XAW'(k);
    f_addr       = k;
    y_addr       = j;
    y_data       = accum_in;
  end

  // Loop counters and enable pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      k         <= '0;
      j         <= '0;
      drain_cnt <= 1'b0;
      en_pipe   <= 2'b00;
    end else begin
      en_pipe   <= {en_pipe[0], issue};
      drain_cnt <= (state == S_DRAIN) && !drain_cnt;
      case (state)
        S_IDLE: begin
          if (start) begin
            j <= '0;
            k <= '0;
          end
        end
        S_RUN: begin
          // k parks at M-1 until CLR rewinds it
          if (!k_last) begin
            k <= k + 1'b1;
          end
        end
        S_CLR: begin
          k <= '0;
          j <= j_last ? '0 : j + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_mac_ctrl.sv
// tb_conv1d_mac_ctrl: drives a small (N=5,M=3) and a default-size
// controller through a memory + MAC environment, checks cycle timing.
module tb_conv1d_mac_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic y_ready = 1'b0;
  logic sel = 1'b0;

  always #5 clk = ~clk;

  logic start_s;
  logic start_b;
  assign start_s = start & ~sel;
  assign start_b = start & sel;

  logic [31:0] accum_in;

  logic        busy_s, done_s, rd_s, mu_s, ad_s, ra_s, va_s;
  logic [2:0]  xa_s;
  logic [1:0]  fa_s;
  logic [1:0]  ya_s;
  logic [31:0] yd_s;

  logic        busy_b, done_b, rd_b, mu_b, ad_b, ra_b, va_b;
  logic [5:0]  xa_b;
  logic [3:0]  fa_b;
  logic [4:0]  ya_b;
  logic [31:0] yd_b;

  conv1d_mac_ctrl #(.N(5), .M(3), .DW(32)) u_small (
    .clk(clk), .reset(reset), .start(start_s),
    .busy(busy_s), .done(done_s), .mem_rd_en(rd_s),
    .x_addr(xa_s), .f_addr(fa_s),
    .en_mult_reg(mu_s), .en_adder_reg(ad_s),
    .reset_accum(ra_s), .accum_in(accum_in),
    .y_valid(va_s), .y_ready(y_ready),
    .y_data(yd_s), .y_addr(ya_s)
  );

  conv1d_mac_ctrl u_big (
    .clk(clk), .reset(reset), .start(start_b),
    .busy(busy_b), .done(done_b), .mem_rd_en(rd_b),
    .x_addr(xa_b), .f_addr(fa_b),
    .en_mult_reg(mu_b), .en_adder_reg(ad_b),
    .reset_accum(ra_b), .accum_in(accum_in),
    .y_valid(va_b), .y_ready(y_ready),
    .y_data(yd_b), .y_addr(ya_b)
  );

  logic busy_w, done_w, rd_w, mu_w, ad_w, ra_w, va_w;
  int   xa_w, fa_w, ya_w, yd_w;

  always_comb begin
    if (sel) begin
      busy_w = busy_b; done_w = done_b; rd_w = rd_b;
      mu_w = mu_b; ad_w = ad_b; ra_w = ra_b; va_w = va_b;
      xa_w = int'(xa_b); fa_w = int'(fa_b);
      ya_w = int'(ya_b); yd_w = int'(yd_b);
    end else begin
      busy_w = busy_s; done_w = done_s; rd_w = rd_s;
      mu_w = mu_s; ad_w = ad_s; ra_w = ra_s; va_w = va_s;
      xa_w = int'(xa_s); fa_w = int'(fa_s);
      ya_w = int'(ya_s); yd_w = int'(yd_s);
    end
  end

  // Memory + MAC environment (1-cycle read latency)
  int xm [64];
  int fm [16];
  int xd = 0;
  int fd = 0;
  int mreg = 0;
  int acc = 0;

  always @(posedge clk) begin
    if (rd_w) begin
      xd <= xm[xa_w];
      fd <= fm[fa_w];
    end
    if (ra_w) begin
      mreg <= 0;
      acc  <= 0;
    end else begin
      if (mu_w) mreg <= xd * fd;
      if (ad_w) acc <= acc + mreg;
    end
  end

  assign accum_in = (acc < 0) ? 32'd0 : 32'(acc);

  int nvec = 0;
  int nerr = 0;
  int cur_rel = 0;
  int exp_y [32];

  typedef struct {
    int f [3];
    int y [3];
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s rel=%0d got %0d want %0d",
               nm, cur_rel, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ctl"},
        int'({busy_w, done_w, rd_w, mu_w, ad_w, va_w}), 0);
    chk({nm, "_racc"}, int'(ra_w), 1);
    chk({nm, "_xa"}, xa_w, 0);
    chk({nm, "_fa"}, fa_w, 0);
    chk({nm, "_ya"}, ya_w, 0);
  endtask

  function automatic int golden(input int j, input int m);
    int s;
    s = 0;
    for (int k = 0; k < m; k++) s += xm[j + k] * fm[k];
    return (s < 0) ? 0 : s;
  endfunction

  // One convolution from a start pulse. The expected waveform is
  // derived from the handshake timeline: output n issues at t0..t0+m-1,
  // OUT from t0+m+2 until accepted at h, CLR at h+1, next t0 = h+2.
  task automatic run(
    input  bit big, input int stall_j, input int stall_n,
    input  bit rnd, input int poke_a, input int poke_b,
    input  int abort_rel,
    output int done_at, output int nstall, output int xmax
  );
    int m, nout, t0, outs, d, rel, hs, nmu, nad;
    bit fin, e_rd, e_mu, e_ad, e_va, e_bu, e_dn, e_ra;
    m = big ? 16 : 3;
    nout = big ? 28 : 3;
    sel = big;
    t0 = 1; outs = 0; hs = 0; nmu = 0; nad = 0;
    done_at = -1; nstall = 0; xmax = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rel = 1;
    while (1) begin
      cur_rel = rel;
      fin = (outs == nout);
      d = rel - t0;
      if (fin && d >= 2) break;
      if (rel > 8000) begin
        chk("timeout", rel, 0);
        break;
      end
      e_rd = !fin && d >= 0 && d < m;
      e_mu = !fin && d >= 1 && d <= m;
      e_ad = !fin && d >= 2 && d <= m + 1;
      e_va = !fin && d >= m + 2;
      e_bu = !fin || d <= 0;
      e_dn = fin && d == 0;
      e_ra = (d == -1) || (fin && d >= 1);
      chk("ctl",
          int'({busy_w, done_w, rd_w, mu_w, ad_w, ra_w, va_w}),
          int'({e_bu, e_dn, e_rd, e_mu, e_ad, e_ra, e_va}));
      if (e_rd) begin
        chk("x_addr", xa_w, outs + d);
        chk("f_addr", fa_w, d);
      end
      if (e_va) begin
        chk("y_addr", ya_w, outs);
        chk("y_data", yd_w, exp_y[outs]);
      end
      if (rd_w && xa_w > xmax) xmax = xa_w;
      if (done_w && done_at < 0) done_at = rel;
      if (mu_w) nmu++;
      if (ad_w) nad++;
      start = (rel == poke_a) || (rel == poke_b);
      if (rnd) y_ready = 1'($urandom_range(0, 1));
      else y_ready = !(outs == stall_j && nstall < stall_n);
      if (va_w && y_ready) hs++;
      if (e_va && !y_ready) nstall++;
      if (e_va && y_ready) begin
        outs++;
        t0 = rel + 2;
      end
      if (rel == abort_rel) reset = 1'b1;
      @(negedge clk);
      rel++;
      if (reset) begin
        cur_rel = rel;
        chk_reset("abort");
        reset = 1'b0;
        start = 1'b0;
        return;
      end
    end
    start = 1'b0;
    chk("handshakes", hs, nout);
    chk("mult_pulses", nmu, nout * m);
    chk("add_pulses", nad, nout * m);
    chk("done_time", done_at, 1 + nout * (m + 4) + nstall);
  endtask

  initial begin
    int da, ns, xmx;
    tbl[0].f = '{1, 0, -1};  tbl[0].y = '{0, 0, 0};
    tbl[1].f = '{1, 1, 1};   tbl[1].y = '{6, 9, 12};
    tbl[2].f = '{0, 0, 1};   tbl[2].y = '{3, 4, 5};
    tbl[3].f = '{2, -1, 0};  tbl[3].y = '{0, 1, 2};
    tbl[4].f = '{-1, 0, 2};  tbl[4].y = '{5, 6, 7};
    for (int i = 0; i < 64; i++) xm[i] = 0;
    for (int i = 0; i < 16; i++) fm[i] = 0;
    for (int i = 0; i < 5; i++) xm[i] = i + 1;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    sel = 1'b0; #1;
    chk_reset("rst_small");
    sel = 1'b1; #1;
    chk_reset("rst_big");
    sel = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 3; i++) begin
        fm[i] = tbl[t].f[i];
        exp_y[i] = tbl[t].y[i];
      end
      run(1'b0, -1, 0, 1'b0, 0, 0, 0, da, ns, xmx);
      chk("tbl_xmax", xmx, 4);
      chk("tbl_done", da, 22);
    end

    fm[0] = 1; fm[1] = 1; fm[2] = 1;
    exp_y[0] = 6; exp_y[1] = 9; exp_y[2] = 12;

    run(1'b0, 1, 5, 1'b0, 0, 0, 0, da, ns, xmx);
    chk("bp_done", da, 27);
    chk("bp_stalls", ns, 5);

    run(1'b0, -1, 0, 1'b0, 2, 6, 0, da, ns, xmx);
    chk("poke_done", da, 22);
    run(1'b0, -1, 0, 1'b0, 13, 22, 0, da, ns, xmx);
    chk("poke2_done", da, 22);

    run(1'b0, -1, 0, 1'b0, 0, 0, 9, da, ns, xmx);
    run(1'b0, -1, 0, 1'b0, 0, 0, 0, da, ns, xmx);
    chk("post_rst_done", da, 22);

    for (int i = 0; i < 43; i++)
      xm[i] = int'($urandom_range(0, 65535)) - 32768;
    for (int i = 0; i < 16; i++)
      fm[i] = int'($urandom_range(0, 65535)) - 32768;
    for (int j = 0; j < 28; j++) exp_y[j] = golden(j, 16);
    run(1'b1, -1, 0, 1'b1, 0, 0, 0, da, ns, xmx);
    chk("big_xmax", xmx, 42);
    chk("big_done", da, 561 + ns);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
